// File: rtl/bus_slave_interface.sv
// 68030 bus slave front-end for a single 32-bit register: strobe sync, decode, wait states, DSACK.
// Optional MAXI030_BYTE_LANES_EN decodes byte_en from cpu_siz/cpu_addr[1:0]; otherwise all lanes.
module bus_slave_interface #(
  parameter logic [31:0] BASE_ADDR   = 32'h0080_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFFC,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_as_n,
  input  logic        cpu_ds_n,
  input  logic        cpu_rw,
  input  logic [1:0]  cpu_siz,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        data_oe,
  output logic [1:0]  dsack_n,
  output logic        cs,
  output logic        write,
  output logic [31:0] write_data,
  output logic [3:0]  byte_en,
  input  logic [31:0] reg_read_data
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_CAPTURE, S_ACK} state_t;

  state_t      state_q;
  logic [1:0]  as_sync_q, ds_sync_q;
  logic [3:0]  cnt_q;
  logic        rw_q, cs_q, write_q, data_oe_q;
  logic [1:0]  dsack_q;
  logic [31:0] rdata_q, wdata_q;
  logic [3:0]  be_q, be_d;
  logic        as_s, ds_s, hit;

  assign as_s = as_sync_q[1];
  assign ds_s = ds_sync_q[1];
  assign hit  = (cpu_addr & ADDR_MASK) == BASE_ADDR;

`ifdef MAXI030_BYTE_LANES_EN
  // Big-endian: offset 0 is D31:24, so lane k drives byte_en[3-k]; lanes past offset 3 drop off.
  always_comb begin
    logic [2:0] n, last;
    n    = (cpu_siz == 2'b00) ? 3'd4 : {1'b0, cpu_siz};
    last = {1'b0, cpu_addr[1:0]} + n - 3'd1;
    be_d = 4'h0;
    for (int k = 0; k < 4; k++)
      be_d[3-k] = (3'(k) >= {1'b0, cpu_addr[1:0]}) && (3'(k) <= last);
  end
`else
  logic unused_siz;
  assign unused_siz = ^cpu_siz;
  assign be_d = 4'hF;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      as_sync_q <= 2'b11;
      ds_sync_q <= 2'b11;
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b1;
      cs_q      <= 1'b0;
      write_q   <= 1'b0;
      data_oe_q <= 1'b0;
      dsack_q   <= 2'b11;
      rdata_q   <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
    end else begin
      as_sync_q <= {as_sync_q[0], cpu_as_n};
      ds_sync_q <= {ds_sync_q[0], cpu_ds_n};
      case (state_q)
        S_IDLE: begin
          if (!as_s && !ds_s && hit) begin
            rw_q    <= cpu_rw;
            wdata_q <= cpu_data_in;
            be_q    <= be_d;
            cnt_q   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_q <= S_ACCESS;
              cs_q    <= 1'b1;
              write_q <= ~cpu_rw;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // AS dropping before the select pulse abandons the cycle silently.
          if (as_s) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= S_ACCESS;
              cs_q    <= 1'b1;
              write_q <= ~rw_q;
            end
          end
        end
        S_ACCESS: begin
          cs_q    <= 1'b0;
          write_q <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (rw_q) rdata_q <= reg_read_data;
          data_oe_q <= rw_q;
          dsack_q   <= 2'b00;
          state_q   <= S_ACK;
        end
        S_ACK: begin
          if (as_s) begin
            dsack_q   <= 2'b11;
            data_oe_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_data_out = rdata_q;
  assign data_oe      = data_oe_q;
  assign dsack_n      = dsack_q;
  assign cs           = cs_q;
  assign write        = write_q;
  assign write_data   = wdata_q;
  assign byte_en      = be_q;

endmodule

// File: tb/tb_bus_slave_interface.sv
// Directed bench for bus_slave_interface (WAIT_STATES = 2); edge 0 is the first edge after strobes fall.
module tb_bus_slave_interface;
  logic        clock = 1'b0, reset = 1'b0;
  logic        cpu_as_n = 1'b1, cpu_ds_n = 1'b1, cpu_rw = 1'b1;
  logic [1:0]  cpu_siz = 2'b00;
  logic [31:0] cpu_addr = 32'h0, cpu_data_in = 32'h0, reg_read_data = 32'h0;
  logic [31:0] cpu_data_out, write_data;
  logic        data_oe, cs, write;
  logic [1:0]  dsack_n;
  logic [3:0]  byte_en;
  int          n_tests = 0, n_fail = 0;

  bus_slave_interface #(.BASE_ADDR(32'h0080_0000), .ADDR_MASK(32'hFFFF_FFFC), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_ds_n(cpu_ds_n), .cpu_rw(cpu_rw),
    .cpu_siz(cpu_siz), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .data_oe(data_oe), .dsack_n(dsack_n), .cs(cs), .write(write), .write_data(write_data),
    .byte_en(byte_en), .reg_read_data(reg_read_data));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic start_cycle(input logic [31:0] a, input logic rw, input logic [1:0] siz, input logic [31:0] d);
    @(negedge clock);
    cpu_addr = a; cpu_rw = rw; cpu_siz = siz; cpu_data_in = d;
    cpu_as_n = 1'b0; cpu_ds_n = 1'b0;
  endtask

  task automatic end_cycle;
    cpu_as_n = 1'b1; cpu_ds_n = 1'b1;
    repeat (6) tick;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    n_tests++;
    if ({cs, write, dsack_n, data_oe} !== 5'b00110) begin
      n_fail++; $display("FAIL reset_ctl got cs/wr/dsack/oe=%b want 00110", {cs, write, dsack_n, data_oe});
    end
    n_tests++;
    if ({cpu_data_out, write_data, byte_en} !== 68'h0) begin
      n_fail++; $display("FAIL reset_data got rd=%h wd=%h be=%h want 0", cpu_data_out, write_data, byte_en);
    end
    @(negedge clock); reset = 1'b1;
    repeat (3) tick;
    n_tests++;
    if ({cs, dsack_n} !== 3'b011) begin
      n_fail++; $display("FAIL reset_idle got cs/dsack=%b want 011", {cs, dsack_n});
    end
  endtask

  task automatic test_write;
    logic       ecs;
    logic [1:0] eds;
    start_cycle(32'h0080_0000, 1'b0, 2'b00, 32'hDEADBEEF);
    for (int e = 0; e <= 11; e++) begin
      tick;
      ecs = (e == 4);
      eds = (e >= 6 && e <= 10) ? 2'b00 : 2'b11;
      n_tests++;
      if ({cs, write, dsack_n} !== {ecs, ecs, eds}) begin
        n_fail++; $display("FAIL write_edge%0d got cs/wr/dsack=%b want %b", e, {cs, write, dsack_n}, {ecs, ecs, eds});
      end
      if (e == 8) begin cpu_as_n = 1'b1; cpu_ds_n = 1'b1; end
    end
    n_tests++;
    if ({write_data, byte_en} !== {32'hDEADBEEF, 4'hF}) begin
      n_fail++; $display("FAIL write_data got wd=%h be=%h want DEADBEEF F", write_data, byte_en);
    end
    repeat (3) tick;
  endtask

  task automatic test_read;
    logic       eoe;
    logic [1:0] eds;
    reg_read_data = 32'hDEADBEEF;
    start_cycle(32'h0080_0000, 1'b1, 2'b00, 32'h0);
    for (int e = 0; e <= 11; e++) begin
      tick;
      eoe = (e >= 6 && e <= 10);
      eds = eoe ? 2'b00 : 2'b11;
      n_tests++;
      if ({cs, write, dsack_n, data_oe} !== {(e == 4), 1'b0, eds, eoe}) begin
        n_fail++; $display("FAIL read_edge%0d got cs/wr/dsack/oe=%b want %b", e, {cs, write, dsack_n, data_oe}, {(e == 4), 1'b0, eds, eoe});
      end
      if (e == 6) begin
        n_tests++;
        if (cpu_data_out !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL read_data got %h want DEADBEEF", cpu_data_out);
        end
      end
      if (e == 8) begin cpu_as_n = 1'b1; cpu_ds_n = 1'b1; end
    end
    reg_read_data = 32'h0;
    repeat (3) tick;
  endtask

  task automatic test_miss;
    int bad = 0;
    start_cycle(32'h00F0_0000, 1'b0, 2'b00, 32'h1234_5678);
    repeat (20) begin
      tick;
      if ({cs, dsack_n} !== 3'b011) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL miss got %0d clocks with cs or dsack active want 0", bad);
    end
    end_cycle;
  endtask

  task automatic test_abort;
    int bad = 0;
    start_cycle(32'h0080_0000, 1'b0, 2'b00, 32'h1234_5678);
    for (int e = 0; e <= 10; e++) begin
      tick;
      if ({cs, dsack_n} !== 3'b011) bad++;
      if (e == 1) begin cpu_as_n = 1'b1; cpu_ds_n = 1'b1; end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL abort got %0d clocks with cs or dsack active want 0", bad);
    end
    start_cycle(32'h0080_0000, 1'b0, 2'b00, 32'h0F0F_0F0F);
    for (int e = 0; e <= 7; e++) begin
      tick;
      n_tests++;
      if ({cs, dsack_n} !== {(e == 4), (e >= 6) ? 2'b00 : 2'b11}) begin
        n_fail++; $display("FAIL abort_next_edge%0d got cs/dsack=%b want %b", e, {cs, dsack_n}, {(e == 4), (e >= 6) ? 2'b00 : 2'b11});
      end
    end
    n_tests++;
    if (write_data !== 32'h0F0F_0F0F) begin
      n_fail++; $display("FAIL abort_next_data got %h want 0F0F0F0F", write_data);
    end
    end_cycle;
  endtask

  task automatic test_byte_lanes;
    logic [1:0] siz_t [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] a_t   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
`ifdef MAXI030_BYTE_LANES_EN
    logic [3:0] be_t  [4] = '{4'b0010, 4'b0110, 4'b0001, 4'b0011};
`else
    logic [3:0] be_t  [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
`endif
    for (int i = 0; i < 4; i++) begin
      start_cycle({30'h0020_0000, a_t[i]}, 1'b0, siz_t[i], 32'hA5A5_0000 + 32'(i));
      repeat (3) tick;
      n_tests++;
      if (byte_en !== be_t[i]) begin
        n_fail++; $display("FAIL byte_en_%0d got %b want %b", i, byte_en, be_t[i]);
      end
      end_cycle;
    end
  endtask

  task automatic test_reset_mid_ack;
    start_cycle(32'h0080_0000, 1'b1, 2'b00, 32'h0);
    reg_read_data = 32'hCAFE_F00D;
    repeat (8) tick;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({cs, write, dsack_n, data_oe} !== 5'b00110) begin
      n_fail++; $display("FAIL reset_mid_ack_ctl got cs/wr/dsack/oe=%b want 00110", {cs, write, dsack_n, data_oe});
    end
    n_tests++;
    if ({cpu_data_out, byte_en} !== 36'h0) begin
      n_fail++; $display("FAIL reset_mid_ack_data got rd=%h be=%h want 0", cpu_data_out, byte_en);
    end
    cpu_as_n = 1'b1; cpu_ds_n = 1'b1;
    @(negedge clock); reset = 1'b1;
    repeat (4) tick;
    n_tests++;
    if ({cs, dsack_n} !== 3'b011) begin
      n_fail++; $display("FAIL reset_release_idle got cs/dsack=%b want 011", {cs, dsack_n});
    end
    start_cycle(32'h0080_0000, 1'b1, 2'b00, 32'h0);
    repeat (7) tick;
    n_tests++;
    if ({dsack_n, data_oe, cpu_data_out} !== {2'b00, 1'b1, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL reset_release_cycle got dsack=%b oe=%b rd=%h want 00 1 CAFEF00D", dsack_n, data_oe, cpu_data_out);
    end
    end_cycle;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_miss;
    test_abort;
    test_byte_lanes;
    test_reset_mid_ack;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
